eth_rx_packet_checker: RTL and testbench
========================================

// Module: eth_rx_packet_checker
// PURPOSE
//  Consumes the Rx AXIS stream from eth_10g (m00_axis_*) and checks every packet against the index-counter
//  test format produced by the Tx packet generator. Beat k of a packet carries k in tdata[15:0]. A packet
//  holds expected_len+1 beats, with tlast on beat expected_len. Keeps saturating good/bad packet counters
//  and a first-error code for VIO/ILA readout in the hardware example. The stream has no tready; the block
//  is always ready.
// PARAMETERS
//  DATA_W   64  AXIS data width; tkeep is DATA_W/8
//  IDX_W    16  width of the per-beat index field in tdata[IDX_W-1:0]
//  CNT_W    32  width of the statistics counters
// PORTS
//  s00_axis_aclk     in   1        clock (the eth_10g m00_axis_aclk domain)
//  s00_axis_aresetn  in   1        asynchronous active-low reset
//  s00_axis_tdata    in   DATA_W   rx beat data
//  s00_axis_tkeep    in   DATA_W/8 byte enables
//  s00_axis_tvalid   in   1        beat valid
//  s00_axis_tlast    in   1        last beat of packet
//  s00_axis_tuser    in   1        MAC error flag, sampled on the tlast beat
//  expected_len      in   IDX_W    index of the last beat; quasi-static, sampled on the first beat of each packet
//  expected_pattern  in   DATA_W-IDX_W  expected tdata[DATA_W-1:IDX_W] (used only with the macro)
//  clear_counters    in   1        synchronous clear of all counters and of err_code
//  pkt_ok_count      out  CNT_W    packets received with no error
//  pkt_err_count     out  CNT_W    packets with one or more errors (at most 1 count per packet)
//  tuser_err_count   out  CNT_W    packets ending with tuser=1
//  err_code          out  3        sticky first error: 0 none, 1 IDX, 2 LEN, 3 KEEP, 4 TUSER, 5 PAT
//  pkt_done          out  1        1-cycle pulse, 1 cycle after a tlast beat
//  pkt_err           out  1        qualifies pkt_done: that packet had an error
// BEHAVIOUR
//  - Reset: all counters 0, err_code 0, pkt_done/pkt_err 0, FSM in IDLE, beat index 0.
//  - Beats are accepted only when tvalid=1. Idle cycles inside a packet are legal and change no state.
//  - FSM IDLE: the first valid beat latches expected_len and goes to IN_PKT. If that beat also has tlast,
//    the packet closes on the same beat (single-beat packet).
//  - IN_PKT: beat_idx increments per beat. Checks applied to each beat:
//    IDX: tdata[IDX_W-1:0] != beat_idx.
//    KEEP: tkeep != all-ones.
//    LEN (short packet): tlast=1 while beat_idx < latched len.
//    LEN (long packet): beat_idx == latched len and tlast=0. On a long-packet error go to DROP.
//  - TUSER: tlast=1 and tuser=1. Counts in both tuser_err_count and pkt_err_count.
//  - DROP: discard beats until tlast, then close the packet as errored. No further checks are made in DROP.
//  - Packet close (tlast beat): next cycle pkt_done=1. Exactly one of pkt_ok_count / pkt_err_count
//    increments. FSM returns to IDLE and beat_idx to 0.
//  - Several errors on one beat: err_code takes the lowest code. err_code holds its first nonzero value
//    until clear_counters.
//  - Counters saturate at all-ones and never wrap.
//  - beat_idx is IDX_W wide and cannot pass the latched length, because the long-packet check fires first.
//  - clear_counters together with a packet close: the clear wins, and the counters read 0 the next cycle.
//  - A mid-packet aresetn assertion aborts the packet and nothing is counted. After release the checker
//    resyncs on the next valid beat, so a partial packet arriving then shows up as IDX/LEN errors.
//  - Latency: statistics are updated 1 cycle after the tlast beat.
// CONFIGURATION
//  ETH_RX_CHECK_PATTERN_EN defined: each beat also compares tdata[DATA_W-1:IDX_W] against
//    expected_pattern. A mismatch is error PAT (code 5).
//  Not defined: the upper data bits are ignored, expected_pattern is unused, and code 5 never occurs.
// STRUCTURE
//  - Package eth_rx_check_pkg holds:
//    the state typedef (IDLE, IN_PKT, DROP);
//    the err_code enum with the code values above;
//    localparam ERR_W=3.
//  - Sub-module eth_sat_counter (parameter W; ports inc, clr, count) is instantiated 3 times.
// TESTING
//  1 expected_len=7; 3 clean 8-beat packets (idx 0..7), tkeep=FF
//    -> pkt_ok_count=3, pkt_err_count=0, err_code=0, three pkt_done pulses with pkt_err=0.
//  2 Beat 3 carries idx 0x0005
//    -> pkt_err_count=1, err_code=1. The next clean packet increments pkt_ok_count.
//  3 tlast on beat 4 with len=7 (short)
//    -> LEN, err_code=2.
//  4 No tlast at beat 7 and 3 extra beats, tlast on the last
//    -> DROP; pkt_err_count +1 exactly once, at the final tlast.
//  5 tuser=1 on the tlast beat of a clean packet
//    -> tuser_err_count=1, pkt_err_count=1, err_code=4.
//  6 Preload counters to all-ones minus 1; send 2 good packets -> count stays all-ones.
//    Assert clear_counters on a close cycle -> all counters 0.
//    With macro defined: a wrong upper pattern gives err_code=5.

Source files
------------

// File: rtl/eth_rx_packet_checker_pkg.sv
// Shared types for the Rx packet checker: FSM states and error codes.
// Optional feature macro: ETH_RX_CHECK_PATTERN_EN (upper-data pattern check).
package eth_rx_check_pkg;

    localparam int ERR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_t;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE  = 3'd0,
        ERR_IDX   = 3'd1,
        ERR_LEN   = 3'd2,
        ERR_KEEP  = 3'd3,
        ERR_TUSER = 3'd4,
        ERR_PAT   = 3'd5
    } err_code_t;

endpackage

// File: rtl/eth_rx_packet_checker_if.sv
// AXIS Rx beat bundle (no tready: the consumer is always ready).
interface eth_rx_packet_checker_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser);
    modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_packet_checker_sat_counter.sv
// Saturating statistics counter with synchronous clear (clear beats increment).
module eth_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    // Count up on inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/eth_rx_packet_checker.sv
// Checks Rx AXIS packets against the index-counter test format and keeps
// saturating good/bad/tuser packet counters plus a sticky first-error code.
// Optional feature macro: ETH_RX_CHECK_PATTERN_EN enables the upper-data
// pattern comparison (error code PAT).
module eth_rx_packet_checker
    import eth_rx_check_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_aresetn,
    eth_rx_packet_checker_if.slave  s00_axis,
    input  logic [IDX_W-1:0]        expected_len,
    input  logic [DATA_W-IDX_W-1:0] expected_pattern,
    input  logic                    clear_counters,
    output logic [CNT_W-1:0]        pkt_ok_count,
    output logic [CNT_W-1:0]        pkt_err_count,
    output logic [CNT_W-1:0]        tuser_err_count,
    output logic [ERR_W-1:0]        err_code,
    output logic                    pkt_done,
    output logic                    pkt_err
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic             err_seen_q, err_seen_d;
    err_code_t        err_code_q, err_code_d;
    logic             pkt_done_q, pkt_err_q;

    logic [IDX_W-1:0] cur_idx, cur_len;
    logic             f_idx, f_short, f_long, f_keep, f_tuser, f_pat;
    logic             checking, close, close_err;
    err_code_t        beat_code;

`ifdef ETH_RX_CHECK_PATTERN_EN
    assign f_pat = s00_axis.tdata[DATA_W-1:IDX_W] != expected_pattern;
`else
    logic unused_pat;
    assign unused_pat = ^{expected_pattern, s00_axis.tdata[DATA_W-1:IDX_W]};
    assign f_pat      = 1'b0;
`endif

    // Per-beat checks; in IDLE the beat is index 0 against the live length input.
    always_comb begin
        cur_idx   = (state_q == IDLE) ? '0 : beat_idx_q;
        cur_len   = (state_q == IDLE) ? expected_len : len_q;
        f_idx     = s00_axis.tdata[IDX_W-1:0] != cur_idx;
        f_short   = s00_axis.tlast && (cur_idx < cur_len);
        f_long    = !s00_axis.tlast && (cur_idx == cur_len);
        f_keep    = s00_axis.tkeep != '1;
        f_tuser   = s00_axis.tlast && s00_axis.tuser;
        checking  = s00_axis.tvalid && (state_q != DROP);
        close     = s00_axis.tvalid && s00_axis.tlast;
        beat_code = ERR_NONE;
        if (f_idx)                   beat_code = ERR_IDX;
        else if (f_short || f_long)  beat_code = ERR_LEN;
        else if (f_keep)             beat_code = ERR_KEEP;
        else if (f_tuser)            beat_code = ERR_TUSER;
        else if (f_pat)              beat_code = ERR_PAT;
        close_err = close && ((state_q == DROP) || err_seen_q ||
                              (checking && (beat_code != ERR_NONE)));
    end

    // FSM next state: track beat index, latch length, divert long packets to DROP.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        len_d      = len_q;
        err_seen_d = err_seen_q;
        if (s00_axis.tvalid) begin
            case (state_q)
                IDLE, IN_PKT: begin
                    len_d = cur_len;
                    if (beat_code != ERR_NONE) err_seen_d = 1'b1;
                    if (s00_axis.tlast) begin
                        state_d    = IDLE;
                        beat_idx_d = '0;
                        err_seen_d = 1'b0;
                    end else if (f_long) begin
                        state_d = DROP;
                    end else begin
                        state_d    = IN_PKT;
                        beat_idx_d = cur_idx + 1'b1;
                    end
                end
                DROP: begin
                    if (s00_axis.tlast) begin
                        state_d    = IDLE;
                        beat_idx_d = '0;
                        err_seen_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    beat_idx_d = '0;
                    err_seen_d = 1'b0;
                end
            endcase
        end
    end

    // Sticky first error; clear wins over any error seen on the same cycle.
    always_comb begin
        err_code_d = err_code_q;
        if (clear_counters) begin
            err_code_d = ERR_NONE;
        end else if ((err_code_q == ERR_NONE) && checking) begin
            err_code_d = beat_code;
        end
    end

    // State, error and close-pulse registers.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
            len_q      <= '0;
            err_seen_q <= 1'b0;
            err_code_q <= ERR_NONE;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            len_q      <= len_d;
            err_seen_q <= err_seen_d;
            err_code_q <= err_code_d;
            pkt_done_q <= close;
            pkt_err_q  <= close_err;
        end
    end

    // Statistics: index 0 good, 1 errored, 2 tuser-flagged packets.
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc[0] = close && !close_err;
    assign cnt_inc[1] = close_err;
    assign cnt_inc[2] = close && checking && f_tuser;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            eth_sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (s00_axis_aclk),
                .rst_n (s00_axis_aresetn),
                .inc   (cnt_inc[gi]),
                .clr   (clear_counters),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign pkt_ok_count    = cnt_val[0];
    assign pkt_err_count   = cnt_val[1];
    assign tuser_err_count = cnt_val[2];
    assign err_code        = err_code_q;
    assign pkt_done        = pkt_done_q;
    assign pkt_err         = pkt_err_q;
endmodule

// File: tb/tb_eth_rx_packet_checker.sv
// Scoreboard bench for eth_rx_packet_checker: a packet-level reference model
// pushes the expected close result per packet; a monitor pops on pkt_done.
// Narrow counters (CNT_W=5) so saturation is reachable quickly.
module tb_eth_rx_packet_checker;
    import eth_rx_check_pkg::*;

    localparam int DATA_W = 64;
    localparam int IDX_W  = 16;
    localparam int CNT_W  = 5;
    localparam int PAT_W  = DATA_W - IDX_W;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IDX_W-1:0] expected_len;
    logic [PAT_W-1:0] expected_pattern;
    logic             clear_counters;
    logic [CNT_W-1:0] pkt_ok_count, pkt_err_count, tuser_err_count;
    logic [ERR_W-1:0] err_code;
    logic             pkt_done, pkt_err;

    eth_rx_packet_checker_if #(.DATA_W(DATA_W)) axis_if ();

    eth_rx_packet_checker #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (axis_if),
        .expected_len     (expected_len),
        .expected_pattern (expected_pattern),
        .clear_counters   (clear_counters),
        .pkt_ok_count     (pkt_ok_count),
        .pkt_err_count    (pkt_err_count),
        .tuser_err_count  (tuser_err_count),
        .err_code         (err_code),
        .pkt_done         (pkt_done),
        .pkt_err          (pkt_err)
    );

    typedef struct { int err; int ok; int bad; int tu; int code; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int m_ok = 0, m_bad = 0, m_tu = 0, m_code = 0;

    logic [DATA_W-1:0] b_data[$];
    logic [7:0]        b_keep[$];
    bit                b_last[$];
    bit                b_user[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every pkt_done must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pkt_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pkt_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pkt_err", int'(pkt_err), e.err);
                chk("pkt_ok_count", int'(pkt_ok_count), e.ok);
                chk("pkt_err_count", int'(pkt_err_count), e.bad);
                chk("tuser_err_count", int'(tuser_err_count), e.tu);
                chk("err_code", int'(err_code), e.code);
                $display("pkt done: err=%0d ok=%0d bad=%0d tuser=%0d code=%0d",
                         pkt_err, pkt_ok_count, pkt_err_count, tuser_err_count, err_code);
            end
        end
    end

    // Build beats: kind 0 clean, 1 bad index, 2 short, 3 long, 4 tuser, 5 keep, 6 pattern.
    task automatic build(input int len, input int kind, input int pos, input int val);
        int nb;
        logic [IDX_W-1:0] idx;
        logic [PAT_W-1:0] upper;
        logic [7:0]       keep;
        b_data.delete(); b_keep.delete(); b_last.delete(); b_user.delete();
        nb = len + 1;
        if (kind == 2) nb = pos + 1;
        if (kind == 3) nb = len + 1 + val;
        for (int k = 0; k < nb; k++) begin
            idx   = IDX_W'(k);
            upper = expected_pattern;
            keep  = 8'hFF;
            if (kind == 1 && k == pos) idx = IDX_W'(val);
            if (kind == 5 && k == pos) keep = 8'(val);
            if (kind == 6 && k == pos) upper = upper ^ (PAT_W'(1) << (val % PAT_W));
            b_data.push_back({upper, idx});
            b_keep.push_back(keep);
            b_last.push_back(k == nb - 1);
            b_user.push_back(kind == 4 && k == nb - 1);
        end
    endtask

    // Reference model: evaluate the whole packet from its beat list.
    task automatic model_pkt(input int len, input bit clr);
        int first = 0, c;
        bit err = 0, tu = 0, drop = 0;
        bit fi, fl, fk, ft, fp;
        exp_t e;
        for (int k = 0; k < b_data.size(); k++) begin
            if (!drop) begin
                fi = b_data[k][IDX_W-1:0] != IDX_W'(k);
                fl = (b_last[k] && k < len) || (!b_last[k] && k == len);
                fk = b_keep[k] != 8'hFF;
                ft = b_last[k] && b_user[k];
`ifdef ETH_RX_CHECK_PATTERN_EN
                fp = b_data[k][DATA_W-1:IDX_W] != expected_pattern;
`else
                fp = 1'b0;
`endif
                c = fi ? 1 : fl ? 2 : fk ? 3 : ft ? 4 : fp ? 5 : 0;
                if (c != 0) begin
                    err = 1;
                    if (first == 0) first = c;
                end
                if (ft) tu = 1;
                if (!b_last[k] && k == len) drop = 1;
            end
        end
        if (clr) begin
            m_ok = 0; m_bad = 0; m_tu = 0; m_code = 0;
        end else begin
            if (err) m_bad = (m_bad == MAXC) ? MAXC : m_bad + 1;
            else     m_ok  = (m_ok  == MAXC) ? MAXC : m_ok + 1;
            if (tu)  m_tu  = (m_tu  == MAXC) ? MAXC : m_tu + 1;
            if (m_code == 0) m_code = first;
        end
        e.err = int'(err); e.ok = m_ok; e.bad = m_bad; e.tu = m_tu; e.code = m_code;
        exp_q.push_back(e);
    endtask

    // Idle cycle with garbage on the data lines (tvalid low must be ignored).
    task automatic idle_cycle();
        axis_if.tvalid = 1'b0;
        axis_if.tdata  = {$urandom, $urandom};
        axis_if.tkeep  = 8'($urandom);
        axis_if.tlast  = 1'($urandom);
        axis_if.tuser  = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic drive_beats(input int len, input bit clr, input int max_gap);
        expected_len = IDX_W'(len);
        for (int k = 0; k < b_data.size(); k++) begin
            int gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) idle_cycle();
            axis_if.tvalid = 1'b1;
            axis_if.tdata  = b_data[k];
            axis_if.tkeep  = b_keep[k];
            axis_if.tlast  = b_last[k];
            axis_if.tuser  = b_user[k];
            clear_counters = clr && b_last[k];
            @(posedge clk); #1;
            axis_if.tvalid = 1'b0;
            clear_counters = 1'b0;
            expected_len   = IDX_W'($urandom);
        end
    endtask

    task automatic send(input int len, input int kind, input int pos, input int val, input bit clr);
        build(len, kind, pos, val);
        model_pkt(len, clr);
        drive_beats(len, clr, 2);
        repeat (2) idle_cycle();
    endtask

    task automatic clear_idle();
        clear_counters = 1'b1;
        idle_cycle();
        clear_counters = 1'b0;
        m_ok = 0; m_bad = 0; m_tu = 0; m_code = 0;
        @(negedge clk);
        chk("clear_ok", int'(pkt_ok_count), 0);
        chk("clear_err", int'(pkt_err_count), 0);
        chk("clear_code", int'(err_code), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int len, kind, pos, val;
        axis_if.tvalid = 1'b0; axis_if.tdata = '0; axis_if.tkeep = '0;
        axis_if.tlast = 1'b0; axis_if.tuser = 1'b0;
        clear_counters = 1'b0;
        expected_len = '0;
        expected_pattern = PAT_W'({$urandom, $urandom});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ok", int'(pkt_ok_count), 0);
        chk("rst_err", int'(pkt_err_count), 0);
        chk("rst_tuser", int'(tuser_err_count), 0);
        chk("rst_code", int'(err_code), 0);
        chk("rst_done", int'(pkt_done), 0);
        @(posedge clk); #1;

        // 1: three clean 8-beat packets
        repeat (3) send(7, 0, 0, 0, 0);
        chk("t1_ok", int'(pkt_ok_count), 3);
        // 2: beat 3 carries index 5, then a clean packet
        send(7, 1, 3, 5, 0);
        chk("t2_err", int'(pkt_err_count), 1);
        chk("t2_code", int'(err_code), 1);
        send(7, 0, 0, 0, 0);
        chk("t2_ok", int'(pkt_ok_count), 4);
        clear_idle();
        // 3: short packet, tlast on beat 4
        send(7, 2, 4, 0, 0);
        chk("t3_code", int'(err_code), 2);
        clear_idle();
        // 4: long packet, three extra beats
        send(7, 3, 0, 3, 0);
        chk("t4_err", int'(pkt_err_count), 1);
        clear_idle();
        // 5: tuser on the tlast beat
        send(7, 4, 0, 0, 0);
        chk("t5_tuser", int'(tuser_err_count), 1);
        chk("t5_code", int'(err_code), 4);
        clear_idle();
        // pattern mismatch: PAT only when the macro is defined, clean otherwise
        send(3, 6, 2, 17, 0);
        clear_idle();
        // 6: saturation then clear on a close cycle
        repeat (MAXC + 1) send(0, 0, 0, 0, 0);
        chk("t6_sat", int'(pkt_ok_count), MAXC);
        send(2, 0, 0, 0, 1);
        chk("t6_clr", int'(pkt_ok_count), 0);

        // mid-packet reset, then the tail arrives as a fresh packet
        send(7, 0, 0, 0, 0);
        build(7, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            b_last[i] = 1'b0;
        end
        begin
            logic [DATA_W-1:0] d_all[$];
            d_all = b_data;
            b_data = d_all[0:3]; b_keep = b_keep[0:3]; b_last = b_last[0:3]; b_user = b_user[0:3];
            drive_beats(7, 0, 1);
            rst_n = 1'b0;
            m_ok = 0; m_bad = 0; m_tu = 0; m_code = 0;
            @(negedge clk);
            chk("mid_rst_ok", int'(pkt_ok_count), 0);
            chk("mid_rst_done", int'(pkt_done), 0);
            @(posedge clk); #1 rst_n = 1'b1;
            build(7, 0, 0, 0);
            d_all = b_data;
            b_data = d_all[4:7]; b_keep = b_keep[4:7]; b_last = b_last[4:7]; b_user = b_user[4:7];
            model_pkt(7, 0);
            drive_beats(7, 0, 1);
            repeat (2) idle_cycle();
        end

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            len  = $urandom_range(0, 9);
            kind = $urandom_range(0, 6);
            pos  = $urandom_range(0, len);
            val  = 0;
            case (kind)
                1: begin val = $urandom_range(0, 65535); if (val == pos) val = pos + 1; end
                2: if (len == 0) kind = 0; else pos = $urandom_range(0, len - 1);
                3: val = $urandom_range(1, 3);
                5: val = $urandom_range(0, 254);
                6: val = $urandom_range(0, PAT_W - 1);
                default: val = 0;
            endcase
            if ($urandom_range(0, 15) == 0) clear_idle();
            send(len, kind, pos, val, $urandom_range(0, 9) == 0);
        end

        repeat (5) idle_cycle();
        chk("pending_expectations", exp_q.size(), 0);
        chk("final_ok", int'(pkt_ok_count), m_ok);
        chk("final_err", int'(pkt_err_count), m_bad);
        chk("final_tuser", int'(tuser_err_count), m_tu);
        chk("final_code", int'(err_code), m_code);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end
endmodule
